// File: rtl/shift_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_ram_ctrl_pkg
//   Shared definitions for the shift-RAM tap-delay controller.
//   - state_t : controller state encodings (INIT / FILL / RUN)
//   - rd_lat  : RAM read latency in cycles for a given OUTPUT_REG setting
// ---------------------------------------------------------------------------
package shift_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // The primitive returns read data one cycle after RE, plus one more
    // cycle when its optional output register is enabled.
    function automatic int rd_lat(input logic output_reg);
        return output_reg ? 2 : 1;
    endfunction

endpackage

// File: rtl/shift_ram_ptr.sv
// ---------------------------------------------------------------------------
// shift_ram_ptr
//   Modulo-DEPTH up-counter with synchronous clear and a wrap flag.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset (count -> 0)
//     clear  in   synchronous clear (count -> 0), wins over inc
//     inc    in   advance by one, wrapping DEPTH-1 -> 0
//     cnt    out  current count
//     wrap   out  high while cnt == DEPTH-1 (next inc wraps)
// ---------------------------------------------------------------------------
module shift_ram_ptr #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  wrap
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/shift_ram_ctrl.sv
// ---------------------------------------------------------------------------
// shift_ram_ctrl
//   Tap-delay line controller for one external read-first BRAM primitive.
//   Every accepted sample is written at PTR while the old content at PTR is
//   read back, so DOUT is the sample accepted exactly DEPTH accepts earlier.
//
//   Optional feature macro: SHIFT_RAM_INIT_CLEAR_EN
//     defined   : reset/clear sweep zeros through the RAM (BUSY high), then
//                 every accept is immediately valid.
//     undefined : no sweep, BUSY tied low, first DEPTH accepts tagged invalid.
//
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     clear                    synchronous restart (RAM contents kept)
//     ce, din                  sample strobe and sample
//     busy                     high while ce cannot be accepted
//     dout, dout_valid         delayed sample and its one-cycle valid pulse
//     ram_we/waddr/wdata       primitive write port
//     ram_re/raddr/rdata       primitive read port
//     ram_waddren/raddren      primitive address enables (tied high)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   INIT    | zero sweep of addresses 0..DEPTH-1, busy (macro builds only)
//   FILL    | first DEPTH accepts; reads return stale data, tagged invalid
//   RUN     | steady state; every accept is tagged valid
// ---------------------------------------------------------------------------
module shift_ram_ctrl
    import shift_ram_ctrl_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   ADDR_WIDTH = 10,
    parameter int   DEPTH      = 1024,
    parameter logic OUTPUT_REG = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_waddren,
    output logic                  ram_raddren
);

    localparam int RD_LAT = rd_lat(OUTPUT_REG);

`ifdef SHIFT_RAM_INIT_CLEAR_EN
    localparam state_t RESTART_ST = ST_INIT;
`else
    localparam state_t RESTART_ST = ST_FILL;
`endif

    state_t                state_q, state_d;
    logic                  accept;
    logic                  in_init;
    logic                  fill_inc;
    logic                  tag_new;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  ptr_wrap_unused;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  fill_last;
    logic [RD_LAT-1:0]     acc_pipe;
    logic [RD_LAT-1:0]     tag_pipe;

`ifdef SHIFT_RAM_INIT_CLEAR_EN
    assign busy = (state_q == ST_INIT);
`else
    assign busy = 1'b0;
`endif

    // A ce coinciding with clear is dropped so the restart begins at PTR=0.
    assign accept  = ce & ~busy & ~clear;
    assign in_init = (state_q == ST_INIT);

    shift_ram_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (accept),
        .cnt   (ptr),
        .wrap  (ptr_wrap_unused)
    );

    // Counts fill accepts in FILL; doubles as the sweep address in INIT.
    shift_ram_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_fill (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (fill_inc),
        .cnt   (fill_cnt),
        .wrap  (fill_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESTART_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fill_inc = 1'b0;
        tag_new  = 1'b0;
        case (state_q)
            ST_INIT: begin
                fill_inc = 1'b1;
                if (fill_last) state_d = ST_RUN;
            end
            ST_FILL: begin
                // The DEPTH-th accept still reads stale data: leave it untagged.
                if (accept) begin
                    fill_inc = 1'b1;
                    if (fill_last) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                tag_new = accept;
            end
            default: begin
                state_d = RESTART_ST;
            end
        endcase
        if (clear) state_d = RESTART_ST;
    end

    assign ram_we      = accept | in_init;
    assign ram_re      = accept;
    assign ram_waddr   = in_init ? fill_cnt : ptr;
    assign ram_raddr   = ptr;
    assign ram_wdata   = in_init ? '0 : din;
    assign ram_waddren = 1'b1;
    assign ram_raddren = 1'b1;

    // acc_pipe tracks reads in flight; its last stage lines up with RAM_RDATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_pipe   <= '0;
            tag_pipe   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            acc_pipe   <= '0;
            tag_pipe   <= '0;
            dout_valid <= 1'b0;
        end else begin
            acc_pipe   <= (acc_pipe << 1) | RD_LAT'(accept);
            tag_pipe   <= (tag_pipe << 1) | RD_LAT'(tag_new);
            dout_valid <= acc_pipe[RD_LAT-1] & tag_pipe[RD_LAT-1];
            if (acc_pipe[RD_LAT-1]) begin
                dout <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_shift_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_ram_ctrl
//   Four controllers share one stimulus stream, each paired with a small
//   read-first RAM model:
//     0: DEPTH=4,  OUTPUT_REG=0      1: DEPTH=4,  OUTPUT_REG=1
//     2: DEPTH=5,  OUTPUT_REG=0      3: DEPTH=16, OUTPUT_REG=0
//   Cycle c is the clock period in which the inputs of the c-th drive() call
//   are applied; outputs are sampled at the falling edge of that period.
// ---------------------------------------------------------------------------
module tb_shift_ram_ctrl;

`ifdef SHIFT_RAM_INIT_CLEAR_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] din = 8'h00;

    logic       busy [4];
    logic [7:0] dout [4];
    logic       dv [4];
    logic       we [4];
    logic [9:0] waddr [4];
    logic [7:0] wdata [4];
    logic       re [4];
    logic [9:0] raddr [4];
    logic [7:0] rdata [4];
    logic       waddren [4];
    logic       raddren [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int   DEP  = (g == 2) ? 5 : (g == 3) ? 16 : 4;
        localparam logic OREG = (g == 1);

        shift_ram_ctrl #(
            .DATA_WIDTH (8),
            .ADDR_WIDTH (10),
            .DEPTH      (DEP),
            .OUTPUT_REG (OREG)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (clear),
            .ce          (ce),
            .din         (din),
            .busy        (busy[g]),
            .dout        (dout[g]),
            .dout_valid  (dv[g]),
            .ram_we      (we[g]),
            .ram_waddr   (waddr[g]),
            .ram_wdata   (wdata[g]),
            .ram_re      (re[g]),
            .ram_raddr   (raddr[g]),
            .ram_rdata   (rdata[g]),
            .ram_waddren (waddren[g]),
            .ram_raddren (raddren[g])
        );

        // Read-first RAM: the read sees the content before this cycle's write.
        logic [7:0] mem [0:1023];
        logic [7:0] rd1 = 8'h00;
        logic [7:0] rd2 = 8'h00;
        always @(posedge clk) begin
            if (we[g]) mem[waddr[g]] <= wdata[g];
            if (re[g]) rd1 <= mem[raddr[g]];
            rd2 <= rd1;
        end
        assign rdata[g] = OREG ? rd2 : rd1;
    end

    task automatic drive(input logic r, input logic c, input logic [7:0] d, input logic cl);
        @(posedge clk);
        #1;
        rst_n = r;
        ce    = c;
        din   = d;
        clear = cl;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (dv[g] !== 1'b0) begin
                errors++; $display("FAIL reset_dv dut%0d got=%b exp=0", g, dv[g]);
            end
            checks++;
            if (dout[g] !== 8'h00) begin
                errors++; $display("FAIL reset_dout dut%0d got=%h exp=00", g, dout[g]);
            end
            checks++;
            if (waddr[g] !== 10'd0 || raddr[g] !== 10'd0) begin
                errors++; $display("FAIL reset_addr dut%0d got=%0d/%0d exp=0/0", g, waddr[g], raddr[g]);
            end
            checks++;
            if (re[g] !== 1'b0) begin
                errors++; $display("FAIL reset_re dut%0d got=%b exp=0", g, re[g]);
            end
            checks++;
            if (busy[g] !== INIT_EN) begin
                errors++; $display("FAIL reset_busy dut%0d got=%b exp=%b", g, busy[g], INIT_EN);
            end
            checks++;
            if (waddren[g] !== 1'b1 || raddren[g] !== 1'b1) begin
                errors++; $display("FAIL addren dut%0d got=%b%b exp=11", g, waddren[g], raddren[g]);
            end
        end
    endtask

    // DEPTH=4, continuous ce, din=1,2,3...; dut0 latency 2, dut1 latency 3.
    task automatic test_continuous();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, 8'(c + 1), 1'b0);
            for (int g = 0; g < 2; g++) begin
                int   lat;
                logic exp_v;
                lat   = 2 + g;
                exp_v = (c >= lat + 4);
                checks++;
                if (dv[g] !== exp_v) begin
                    errors++; $display("FAIL cont_dv dut%0d c=%0d got=%b exp=%b", g, c, dv[g], exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (dout[g] !== 8'(c - lat - 3)) begin
                        errors++; $display("FAIL cont_dout dut%0d c=%0d got=%0d exp=%0d", g, c, dout[g], c - lat - 3);
                    end
                end
                checks++;
                if (waddr[g] !== 10'(c % 4) || raddr[g] !== 10'(c % 4)) begin
                    errors++; $display("FAIL cont_addr dut%0d c=%0d got=%0d exp=%0d", g, c, waddr[g], c % 4);
                end
            end
            checks++;
            if (we[0] !== 1'b1 || re[0] !== 1'b1 || wdata[0] !== 8'(c + 1)) begin
                errors++; $display("FAIL cont_wport c=%0d got=%b%b/%0d exp=11/%0d", c, we[0], re[0], wdata[0], c + 1);
            end
        end
    endtask

    // DEPTH=5, ce toggling 1,0; accept k (din=k) issued at cycle 2(k-1).
    task automatic test_nonpow2();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 40; c++) begin
            logic a;
            logic exp_v;
            a = (c % 2 == 0);
            drive(1'b1, a, a ? 8'(c / 2 + 1) : 8'hAA, 1'b0);
            exp_v = (c % 2 == 0) && (c >= 12);
            checks++;
            if (dv[2] !== exp_v) begin
                errors++; $display("FAIL np2_dv c=%0d got=%b exp=%b", c, dv[2], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (dout[2] !== 8'(c / 2 - 5)) begin
                    errors++; $display("FAIL np2_dout c=%0d got=%0d exp=%0d", c, dout[2], c / 2 - 5);
                end
            end
            checks++;
            if (waddr[2] !== 10'(((c + 1) / 2) % 5)) begin
                errors++; $display("FAIL np2_waddr c=%0d got=%0d exp=%0d", c, waddr[2], ((c + 1) / 2) % 5);
            end
            checks++;
            if (we[2] !== a) begin
                errors++; $display("FAIL np2_we c=%0d got=%b exp=%b", c, we[2], a);
            end
        end
    endtask

    // DEPTH=4: 7 accepts, clear with a dropped ce, then din=100,101,...
    task automatic test_clear();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 7; c++) drive(1'b1, 1'b1, 8'(c + 1), 1'b0);
        drive(1'b1, 1'b1, 8'd99, 1'b1);
        checks++;
        if (we[0] !== 1'b0) begin
            errors++; $display("FAIL clr_drop_we got=%b exp=0", we[0]);
        end
        checks++;
        if (dv[0] !== 1'b1 || dout[0] !== 8'd2) begin
            errors++; $display("FAIL clr_pre got=%b/%0d exp=1/2", dv[0], dout[0]);
        end
        for (int c = 8; c < 20; c++) begin
            logic exp_v;
            drive(1'b1, 1'b1, 8'(100 + c - 8), 1'b0);
            exp_v = (c >= 14);
            checks++;
            if (dv[0] !== exp_v) begin
                errors++; $display("FAIL clr_dv c=%0d got=%b exp=%b", c, dv[0], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (dout[0] !== 8'(100 + c - 14)) begin
                    errors++; $display("FAIL clr_dout c=%0d got=%0d exp=%0d", c, dout[0], 100 + c - 14);
                end
            end
            if (c < 10) begin
                checks++;
                if (dout[0] !== 8'd2) begin
                    errors++; $display("FAIL clr_hold c=%0d got=%0d exp=2", c, dout[0]);
                end
            end
            if (c == 8) begin
                checks++;
                if (waddr[0] !== 10'd0) begin
                    errors++; $display("FAIL clr_ptr got=%0d exp=0", waddr[0]);
                end
            end
        end
    endtask

    // DEPTH=4: reset pulsed mid-stream, then refill with din=50,51,...
    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 8; c++) drive(1'b1, 1'b1, 8'(c + 1), 1'b0);
        checks++;
        if (dv[0] !== 1'b1 || dout[0] !== 8'd2) begin
            errors++; $display("FAIL rstm_pre got=%b/%0d exp=1/2", dv[0], dout[0]);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (dv[0] !== 1'b0 || dout[0] !== 8'h00 || waddr[0] !== 10'd0) begin
            errors++; $display("FAIL rstm_async got=%b/%0d/%0d exp=0/0/0", dv[0], dout[0], waddr[0]);
        end
        for (int c = 9; c < 21; c++) begin
            logic exp_v;
            drive(1'b1, 1'b1, 8'(50 + c - 9), 1'b0);
            exp_v = (c >= 15);
            checks++;
            if (dv[0] !== exp_v) begin
                errors++; $display("FAIL rstm_dv c=%0d got=%b exp=%b", c, dv[0], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (dout[0] !== 8'(50 + c - 15)) begin
                    errors++; $display("FAIL rstm_dout c=%0d got=%0d exp=%0d", c, dout[0], 50 + c - 15);
                end
            end
        end
    endtask

    // DEPTH=16 with the zero sweep: 16 busy cycles, then zeros valid at once.
    task automatic test_init_clear();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 1'b1, 8'd77, 1'b0);
            checks++;
            if (busy[3] !== 1'b1 || we[3] !== 1'b1 || re[3] !== 1'b0) begin
                errors++; $display("FAIL init_ctl c=%0d got=%b%b%b exp=110", c, busy[3], we[3], re[3]);
            end
            checks++;
            if (wdata[3] !== 8'h00 || waddr[3] !== 10'(c)) begin
                errors++; $display("FAIL init_wr c=%0d got=%0d@%0d exp=0@%0d", c, wdata[3], waddr[3], c);
            end
        end
        for (int c = 16; c < 41; c++) begin
            logic exp_v;
            drive(1'b1, 1'b1, 8'(c), 1'b0);
            exp_v = (c >= 18);
            checks++;
            if (busy[3] !== 1'b0 || dv[3] !== exp_v) begin
                errors++; $display("FAIL init_run c=%0d got=%b/%b exp=0/%b", c, busy[3], dv[3], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (dout[3] !== ((c < 34) ? 8'd0 : 8'(c - 18))) begin
                    errors++; $display("FAIL init_dout c=%0d got=%0d exp=%0d", c, dout[3], (c < 34) ? 0 : c - 18);
                end
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef SHIFT_RAM_INIT_CLEAR_EN
        test_init_clear();
`else
        test_continuous();
        test_nonpow2();
        test_clear();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
